// File: rtl/ozone_uop_pkg.sv
// ozone_uop_pkg: micro-op encoding shared by the sequencer and the instruction queue
package ozone_uop_pkg;
  typedef enum logic [3:0] {UOP_NOP, UOP_ADD, UOP_SUB, UOP_LOAD, UOP_STORE, UOP_BRANCH} uop_code;
  typedef logic [4:0] uop_reg;
  typedef struct packed {uop_reg rd; uop_reg rs1; uop_reg rs2;} uop_rr;
  typedef struct packed {uop_reg rd; uop_reg rs1; logic [4:0] imm;} uop_ri;
  typedef struct packed {uop_reg rs1; logic [9:0] disp;} uop_branch;
  typedef union packed {uop_rr rr; uop_ri ri; uop_branch br;} uop_args;
  typedef struct packed {
    uop_code code;
    uop_args args;
    logic    tx_begin;
    logic    tx_end;
  } uop_insn;
endpackage

// File: rtl/uop_chunk_select.sv
// uop_chunk_select: picks the next n buffered micro-ops, stamps macro-op boundaries, zeroes idle lanes
module uop_chunk_select
  import ozone_uop_pkg::*;
#(
  parameter int MAX_UOPS = 4,
  parameter int Q_WIDTH  = 2
) (
  input  uop_insn [MAX_UOPS-1:0]           uop_buf,
  input  logic [$clog2(MAX_UOPS+1)-1:0]    off,
  input  logic [$clog2(MAX_UOPS+1)-1:0]    cnt,
  input  logic [$clog2(Q_WIDTH+1)-1:0]     n,
  output uop_insn [Q_WIDTH-1:0]            lanes
);
  localparam int IW = $clog2(MAX_UOPS + Q_WIDTH + 1);
  localparam int AW = MAX_UOPS > 1 ? $clog2(MAX_UOPS) : 1;
  localparam int EW = $clog2(Q_WIDTH + 1);
  for (genvar i = 0; i < Q_WIDTH; i++) begin : g_lane
    logic [IW-1:0] idx;
    uop_insn u;
    always_comb begin
      idx = IW'(off) + IW'(i);
      u = uop_buf[idx[AW-1:0]];
      u.tx_begin = idx == '0;
      u.tx_end = idx + IW'(1) == IW'(cnt);
    end
    assign lanes[i] = (EW'(i) < n && idx < IW'(MAX_UOPS)) ? u : '0;
  end
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: buffers one cracked macro-op and streams its micro-ops into the
// instruction queue, never exceeding write width or free queue space
module uop_sequencer
  import ozone_uop_pkg::*;
#(
  parameter int Q_DEPTH  = 32,
  parameter int Q_WIDTH  = 2,
  parameter int MAX_UOPS = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_N_in,
  input  logic                             flush_in,
  input  logic                             mop_valid_in,
  output logic                             mop_ready_out,
  input  uop_insn [MAX_UOPS-1:0]           mop_uops_in,
  input  logic [$clog2(MAX_UOPS+1)-1:0]    mop_count_in,
  input  logic [$clog2(Q_DEPTH+1)-1:0]     q_size_in,
  output uop_insn [Q_WIDTH-1:0]            q_data_out,
  output logic [$clog2(Q_WIDTH+1)-1:0]     enq_out
);
  localparam int CW = $clog2(MAX_UOPS + 1);
  localparam int SW = $clog2(Q_DEPTH + 1);
  localparam int EW = $clog2(Q_WIDTH + 1);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  uop_insn [MAX_UOPS-1:0] uop_buf;
  logic [CW-1:0] cnt, off, cnt_in;
  logic [SW-1:0] free, rem, room;
  logic [EW-1:0] n;
  logic active, last, accept;
  // An occupancy above capacity is treated as a full queue rather than wrapping.
  always_comb begin
    free = q_size_in > SW'(Q_DEPTH) ? '0 : SW'(Q_DEPTH) - q_size_in;
    rem = SW'(cnt) - SW'(off);
    room = rem < SW'(Q_WIDTH) ? rem : SW'(Q_WIDTH);
    room = free < room ? free : room;
    active = rst_N_in && !flush_in && state == EMIT;
    n = active ? EW'(room) : '0;
    last = active && SW'(off) + SW'(n) == SW'(cnt);
    mop_ready_out = rst_N_in && !flush_in && (state == IDLE || last);
    accept = mop_valid_in && mop_ready_out;
    cnt_in = mop_count_in > CW'(MAX_UOPS) ? CW'(MAX_UOPS) : mop_count_in;
  end
  assign enq_out = n;
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state <= IDLE;
      uop_buf <= '0;
      cnt <= '0;
      off <= '0;
    end else if (flush_in) begin
      state <= IDLE;
      cnt <= '0;
      off <= '0;
    end else if (accept) begin
      uop_buf <= mop_uops_in;
      cnt <= cnt_in;
      off <= '0;
      state <= cnt_in == '0 ? IDLE : EMIT;
    end else if (state == EMIT) begin
      off <= off + CW'(n);
      state <= last ? IDLE : EMIT;
    end
  end
  uop_chunk_select #(.MAX_UOPS(MAX_UOPS), .Q_WIDTH(Q_WIDTH)) u_sel (
    .uop_buf(uop_buf),
    .off(off),
    .cnt(cnt),
    .n(n),
    .lanes(q_data_out)
  );
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed steps with a micro-op scoreboard checked on every enqueued lane
module tb_uop_sequencer;
  import ozone_uop_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, mop_valid = 0, mop_ready;
  uop_insn [3:0] mop_uops = '0;
  logic [2:0] mop_count = '0;
  logic [5:0] q_size = '0;
  uop_insn [1:0] q_data;
  logic [1:0] enq;
  int checks = 0, errors = 0;
  uop_insn sb[$];
  uop_sequencer dut (
    .clk_in(clk), .rst_N_in(rst_n), .flush_in(flush), .mop_valid_in(mop_valid),
    .mop_ready_out(mop_ready), .mop_uops_in(mop_uops), .mop_count_in(mop_count),
    .q_size_in(q_size), .q_data_out(q_data), .enq_out(enq)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic uop_insn mk(input uop_code c, input int a, input int b, input int d);
    uop_insn u;
    u.code = c;
    u.args.rr.rd = 5'(a);
    u.args.rr.rs1 = 5'(b);
    u.args.rr.rs2 = 5'(d);
    u.tx_begin = 1'b1;
    u.tx_end = 1'b1;
    return u;
  endfunction
  // Expected stream: the first push_n micro-ops, with boundaries derived from the clamped count.
  task automatic offer(input uop_insn [3:0] u, input int cnt, input int push_n);
    int clamped;
    uop_insn e;
    clamped = cnt > 4 ? 4 : cnt;
    mop_uops = u;
    mop_count = 3'(cnt);
    mop_valid = 1'b1;
    for (int i = 0; i < push_n; i++) begin
      e = u[i];
      e.tx_begin = i == 0;
      e.tx_end = i == clamped - 1;
      sb.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (i < int'(enq)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected observed=lane%0d expected=no_output", i);
          end else chk("sb_lane", 32'(q_data[i]), 32'(sb.pop_front()));
        end else chk("lane_zero", 32'(q_data[i]), 0);
      end
    end
  end
  initial begin
    uop_insn [3:0] u;
    u = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", mop_ready, 0);
    chk("rst_enq", enq, 0);
    chk("rst_l0", 32'(q_data[0]), 0);
    chk("rst_l1", 32'(q_data[1]), 0);
    tick();
    rst_n = 1;
    // single-uop macro-op
    u[0] = mk(UOP_ADD, 1, 2, 3);
    offer(u, 1, 1);
    @(negedge clk);
    chk("t1_ready", mop_ready, 1);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("t1_enq", enq, 1);
    chk("t1_tb", q_data[0].tx_begin, 1);
    chk("t1_te", q_data[0].tx_end, 1);
    chk("t1_l1", 32'(q_data[1]), 0);
    tick();
    // three uops split over two cycles
    u[0] = mk(UOP_LOAD, 4, 5, 6);
    u[1] = mk(UOP_ADD, 7, 4, 1);
    u[2] = mk(UOP_ADD, 8, 7, 2);
    offer(u, 3, 3);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("t2_enq1", enq, 2);
    chk("t2_tb", q_data[0].tx_begin, 1);
    chk("t2_rdy1", mop_ready, 0);
    tick();
    @(negedge clk);
    chk("t2_enq2", enq, 1);
    chk("t2_te", q_data[0].tx_end, 1);
    chk("t2_rdy2", mop_ready, 1);
    tick();
    // backpressure, including an occupancy report above capacity
    u[0] = mk(UOP_STORE, 9, 10, 11);
    u[1] = mk(UOP_SUB, 12, 13, 14);
    u[2] = mk(UOP_BRANCH, 15, 16, 17);
    u[3] = mk(UOP_NOP, 18, 19, 20);
    q_size = 40;
    offer(u, 4, 4);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("bp_over_enq", enq, 0);
    chk("bp_over_rdy", mop_ready, 0);
    tick();
    q_size = 32;
    @(negedge clk);
    chk("bp_full_enq", enq, 0);
    tick();
    q_size = 31;
    @(negedge clk);
    chk("bp_31_enq", enq, 1);
    chk("bp_31_tb", q_data[0].tx_begin, 1);
    tick();
    q_size = 30;
    @(negedge clk);
    chk("bp_30_enq", enq, 2);
    tick();
    q_size = 0;
    @(negedge clk);
    chk("bp_last_enq", enq, 1);
    chk("bp_last_te", q_data[0].tx_end, 1);
    chk("bp_last_rdy", mop_ready, 1);
    tick();
    @(negedge clk);
    chk("bp_idle_enq", enq, 0);
    chk("bp_idle_rdy", mop_ready, 1);
    // back-to-back two-uop macro-ops
    u = '0;
    u[0] = mk(UOP_ADD, 21, 22, 23);
    u[1] = mk(UOP_SUB, 24, 25, 26);
    offer(u, 2, 2);
    tick();
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) begin
        u[0] = mk(UOP_LOAD, k, k + 1, k + 2);
        u[1] = mk(UOP_ADD, k + 3, k + 4, k + 5);
        offer(u, 2, 2);
      end else mop_valid = 0;
      @(negedge clk);
      chk("b2b_enq", enq, 2);
      chk("b2b_tb", q_data[0].tx_begin, 1);
      chk("b2b_te", q_data[1].tx_end, 1);
      chk("b2b_rdy", mop_ready, 1);
      tick();
    end
    // flush in the middle of a four-uop macro-op
    u[0] = mk(UOP_ADD, 1, 1, 1);
    u[1] = mk(UOP_ADD, 2, 2, 2);
    u[2] = mk(UOP_SUB, 3, 3, 3);
    u[3] = mk(UOP_SUB, 4, 4, 4);
    offer(u, 4, 2);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("fl_enq_first", enq, 2);
    tick();
    flush = 1;
    offer(u, 2, 0);
    @(negedge clk);
    chk("fl_enq", enq, 0);
    chk("fl_rdy", mop_ready, 0);
    tick();
    flush = 0;
    mop_valid = 0;
    @(negedge clk);
    chk("fl_idle_rdy", mop_ready, 1);
    chk("fl_idle_enq", enq, 0);
    tick();
    @(negedge clk);
    chk("fl_after_enq", enq, 0);
    // zero-count macro-op is dropped
    offer(u, 0, 0);
    @(negedge clk);
    chk("z_rdy", mop_ready, 1);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("z_enq", enq, 0);
    chk("z_rdy_idle", mop_ready, 1);
    // oversized count is clamped to four
    u[2] = mk(UOP_BRANCH, 5, 6, 7);
    offer(u, 7, 4);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("cl_enq1", enq, 2);
    tick();
    @(negedge clk);
    chk("cl_enq2", enq, 2);
    chk("cl_rdy", mop_ready, 1);
    tick();
    @(negedge clk);
    chk("cl_enq3", enq, 0);
    // asynchronous reset mid-emit
    offer(u, 4, 2);
    tick();
    mop_valid = 0;
    @(negedge clk);
    chk("ar_enq_first", enq, 2);
    tick();
    rst_n = 0;
    #1;
    chk("ar_enq", enq, 0);
    chk("ar_rdy", mop_ready, 0);
    chk("ar_l0", 32'(q_data[0]), 0);
    chk("ar_l1", 32'(q_data[1]), 0);
    tick();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("ar_rdy_after", mop_ready, 1);
    chk("ar_enq_after", enq, 0);
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uop_sequencer.md
# uop_sequencer

Producer-side front end of the instruction queue: accepts one cracked macro-op (1..MAX_UOPS micro-ops) per handshake from the decoder. It pushes those micro-ops into the instruction queue in chunks of up to Q_WIDTH per cycle, and marks each macro-op's first and last micro-op with tx_begin/tx_end for precise exceptions. It is the block that decides how many micro-ops are safe to enqueue, using the queue's reported occupancy.

## Interface
- Q_DEPTH, 32, instruction-queue capacity in entries
- Q_WIDTH, 2, max micro-ops enqueued per cycle (queue write width)
- MAX_UOPS, 4, max micro-ops per macro-op; must be >= 1
- clk_in  in  1  clock; all state updates on posedge
- rst_N_in  in  1  reset; asynchronous, active-low
- flush_in  in  1  synchronous flush; drops any buffered macro-op
- mop_valid_in  in  1  decoder offers a macro-op
- mop_ready_out  out  1  sequencer accepts the macro-op this cycle
- mop_uops_in  in  MAX_UOPS x uop_insn  micro-ops, index 0 first; tx_begin/tx_end fields ignored
- mop_count_in  in  $clog2(MAX_UOPS+1)  number of valid micro-ops
- q_size_in  in  $clog2(Q_DEPTH+1)  current queue occupancy
- q_data_out  out  Q_WIDTH x uop_insn  micro-ops to write, lane 0 first
- enq_out  out  $clog2(Q_WIDTH+1)  number of lanes of q_data_out to enqueue this cycle

## Operation
- State machine: IDLE and EMIT. Registers: buf (MAX_UOPS x uop_insn), cnt (latched count), off (next index to emit).
- Accept: the handshake completes when mop_valid_in && mop_ready_out at posedge.
  - On accept, latch mop_uops_in into buf and min(mop_count_in, MAX_UOPS) into cnt.
  - Set off = 0 and go to EMIT.
  - If the latched count is 0, the macro-op is dropped and the state stays IDLE.
- Emit count, computed combinationally in EMIT: free = Q_DEPTH - q_size_in; n = min(Q_WIDTH, cnt - off, free).
  - In IDLE, during flush, or while in reset, n = 0.
  - Arithmetic is done at $clog2(Q_DEPTH+1) bits. If q_size_in > Q_DEPTH, free is 0.
- enq_out = n.
- q_data_out[i] for i < n equals buf[off+i], with these fields overridden:
  - tx_begin = (off+i == 0)
  - tx_end = (off+i == cnt-1)
- q_data_out lanes i >= n are all-zero.
- At posedge in EMIT: off <= off + n. If off + n == cnt (last chunk), go to IDLE, unless a new macro-op is accepted in the same cycle, in which case stay in EMIT with the new buffer.
- mop_ready_out = rst_N_in && !flush_in && (state == IDLE || last chunk emits this cycle).
- A single-micro-op macro-op has tx_begin = tx_end = 1 on the same lane.
- Flush: at posedge with flush_in = 1, go to IDLE, set off = 0 and cnt = 0. No accept and no enqueue occur in the flush cycle.
- Reset while asserted:
  - state IDLE, off = 0, cnt = 0, buf = 0
  - outputs enq_out = 0, q_data_out = 0, mop_ready_out = 0
- Reset mid-EMIT discards the partial macro-op. Micro-ops already enqueued are the queue's responsibility, since the queue is reset by the same signal.

## Timing
- Accept-to-first-enqueue latency is 1 cycle; there is no combinational bypass from mop_uops_in to q_data_out.
- Outputs are combinational from registered state plus q_size_in. The queue's size updates at the same edge as its tail, so q_size_in never omits an in-flight enqueue.
- Throughput: a macro-op of k micro-ops occupies ceil(k/Q_WIDTH) cycles of EMIT with an unconstrained queue. The next macro-op is accepted in the last chunk cycle, giving no bubble between macro-ops.
- Backpressure: when free = 0, EMIT holds with enq_out = 0 and all state unchanged. It resumes in the first cycle free > 0.
- Partial space: when free = 1 and Q_WIDTH = 2, exactly one micro-op is emitted, in lane 0.

## Structure
- Shared package ozone_uop_pkg holds uop_code, uop_reg, uop_rr, uop_ri, uop_branch and uop_insn. This block and the instruction queue both import it.
- One sub-module, uop_chunk_select, is natural. It is combinational and takes buf, off, cnt and n. It produces q_data_out with tx_begin/tx_end stamped and unused lanes zeroed.
- The min/free computation and the FSM live in uop_sequencer.

## Test plan
- Reset, then a 1-uop ADD with count 1 and q_size_in 0:
  - accepted the cycle after reset release
  - next cycle enq_out = 1, lane 0 has tx_begin = 1 and tx_end = 1, lane 1 is zero
- 3-uop macro-op (LOAD, ADD, ADD) with q_size_in 0:
  - cycle 1: enq_out = 2, lane 0 has tx_begin = 1
  - cycle 2: enq_out = 1, lane 0 has tx_end = 1, and mop_ready_out = 1 that cycle
- Backpressure on a 4-uop macro-op:
  - q_size_in 32 → enq_out = 0 and hold
  - q_size_in 31 → enq_out = 1
  - q_size_in 30 → enq_out = 2
  - final off = 4 → IDLE
- Back-to-back 2-uop macro-ops with valid held high: enq_out = 2 on every cycle, with tx_begin on lane 0 and tx_end on lane 1 each cycle.
- flush_in during off = 2 of a 4-uop macro-op:
  - that cycle enq_out = 0 and mop_ready_out = 0
  - next cycle IDLE with mop_ready_out = 1
  - the remaining micro-ops are never emitted
- count 0 accepted → no enqueue and the state stays IDLE. count 7 with MAX_UOPS = 4 → clamped, exactly 4 micro-ops emitted. rst_N_in low mid-EMIT → all outputs 0 immediately (asynchronous).
